sm_step_ctrl: RTL and testbench
===============================

SM_STEP_CTRL -- requirements
Module: sm_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, cycles an input must stay stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter PRESCALE, default 10, fixed log2 prescale added to clkDevide.
REQ-003 Port clkIn  input  1  single clock for all logic.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port runSw  input  1  asynchronous level: 1 = free-run, 0 = single-step.
REQ-006 Port stepKey_n  input  1  asynchronous active-low push-button; each press requests one step.
REQ-007 Port clkDevide  input  4  run-rate select; tick period = 2^(clkDevide+PRESCALE) cycles.
REQ-008 Port tick  output  1  one-cycle CPU enable pulse.
REQ-009 Port clkOut  output  1  toggles on every tick, for LED display.
REQ-010 Port stepCount  output  16  number of ticks issued, wraps.
REQ-011 Port mode  output  2  current FSM state encoding.

Function
REQ-012 runSw and stepKey_n SHALL pass through 2-flop synchronizers, then through a debouncer; the latency from a stable input to the debounced output SHALL be 2+DEBOUNCE_CYCLES cycles.
REQ-013 The FSM SHALL have four states: STEP_IDLE=0, RUN=1, STEP_FIRE=2 and STEP_HOLD=3.
REQ-014 STEP_IDLE -> RUN when debounced run=1.
REQ-015 STEP_IDLE -> STEP_FIRE on a debounced press, i.e. a 1->0 transition of the debounced key.
REQ-016 STEP_FIRE SHALL assert tick for exactly 1 cycle, then go -> STEP_HOLD.
REQ-017 STEP_HOLD -> STEP_IDLE on debounced release; no further ticks SHALL be issued while the key is held.
REQ-018 RUN -> STEP_IDLE when debounced run=0; the divider SHALL be cleared on exit.
REQ-019 In RUN, a divider counter (width 15+PRESCALE) SHALL increment every cycle.
REQ-020 In RUN, when counter >= 2^(clkDevide+PRESCALE)-1 the block SHALL pulse tick and clear the counter; the first tick SHALL come 2^(clkDevide+PRESCALE) cycles after entering RUN.
REQ-021 A clkDevide change mid-run SHALL take effect immediately; if the counter is already beyond the new terminal count, tick fires on the next cycle.
REQ-022 Priority: run beats step; a press detected while run=1 SHALL be ignored, and a debounced run=1 arriving in STEP_HOLD SHALL go directly -> RUN.
REQ-023 tick SHALL never be asserted on two consecutive cycles, except in RUN when clkDevide=0 and PRESCALE=0 (tick every cycle).
REQ-024 stepCount SHALL increment by 1 on every tick; 16'hFFFF SHALL wrap to 0.
REQ-025 clkOut SHALL toggle on every tick.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Asserting rst_n=0 SHALL take effect asynchronously at any time, including mid-run and mid-debounce.
REQ-028 Reset values: state=STEP_IDLE, tick=0, clkOut=0, stepCount=0, divider=0, synchronizers=idle level (run=0, key=1), debounce counters=0.
REQ-029 After reset release, no tick SHALL be issued until a debounced run or press event occurs.

Structure
REQ-030 A shared package sm_step_pkg SHALL hold the state enum and its encodings, the STEP_COUNT_W=16 constant and the DIV_W=4 constant.
REQ-031 One sub-module, sm_debounce, SHALL be instantiated twice (run, key); it contains the synchronizer, the stability counter and a stable-level output.
REQ-032 The FSM, the divider and the counters SHALL reside in sm_step_ctrl; no derived clocks SHALL be generated, and tick is an enable only.

Verification (DEBOUNCE_CYCLES=4, PRESCALE=0)
REQ-033 Step: run=0; press key for 20 cycles, release -> exactly 1 tick, stepCount=1, clkOut=1.
REQ-034 Bounce: key toggles every 2 cycles for 12 cycles, then held low -> exactly 1 tick, no earlier.
REQ-035 Run: run=1, clkDevide=3 -> first tick 8 cycles after RUN entry, then every 8 cycles; after 100 ticks stepCount=100.
REQ-036 Rate change: in RUN at counter=6, clkDevide 3->1 -> tick on the next cycle, then every 2 cycles.
REQ-037 Wrap and precedence: preload with 65535 ticks, one more tick -> stepCount=0; press key while run=1 -> no extra tick.
REQ-038 Reset mid-run: rst_n=0 asynchronously -> all outputs 0 in the same cycle; after release, no tick until a new event.

Source files
------------

// File: rtl/sm_step_pkg.sv
// rtl/sm_step_pkg.sv - shared state encoding and width constants for the step/run clock controller
// Purpose: state enum used by sm_step_ctrl and its mode output, plus width constants.
// Ports: none (package).
package sm_step_pkg;

  localparam int STEP_COUNT_W = 16;
  localparam int DIV_W        = 4;

  typedef enum logic [1:0] {
    STEP_IDLE = 2'd0,
    RUN       = 2'd1,
    STEP_FIRE = 2'd2,
    STEP_HOLD = 2'd3
  } step_state_e;

endpackage

// File: rtl/sm_debounce.sv
// rtl/sm_debounce.sv - two-flop synchronizer followed by a stability-count debouncer
// Purpose: accepts a new level on dout only after the synchronized input has
//          differed from dout for DEBOUNCE_CYCLES consecutive cycles, giving a
//          total latency of 2+DEBOUNCE_CYCLES cycles from a stable input.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   din   - asynchronous raw input
//   dout  - debounced, registered level (IDLE_LEVEL after reset)
module sm_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{IDLE_LEVEL}};
      cnt    <= '0;
      dout   <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[0], din};
      // Any sample matching the accepted level restarts the stability window.
      if (sync_q[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync_q[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sm_step_ctrl.sv
// rtl/sm_step_ctrl.sv - single-step / free-run CPU clock-enable generator
// Purpose: issues one-cycle tick enables either one per debounced key press
//          (single-step) or at a programmable rate (free-run); no derived clocks.
// Ports:
//   clkIn     - single clock for all logic
//   rst_n     - asynchronous active-low reset
//   runSw     - async level, 1 = free-run, 0 = single-step
//   stepKey_n - async active-low push-button, one step per press
//   clkDevide - run rate select, tick period = 2^(clkDevide+PRESCALE) cycles
//   tick      - one-cycle CPU enable pulse
//   clkOut    - toggles on every tick (LED)
//   stepCount - number of ticks issued, wraps
//   mode      - current state encoding
module sm_step_ctrl
  import sm_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PRESCALE        = 10
) (
  input  logic                    clkIn,
  input  logic                    rst_n,
  input  logic                    runSw,
  input  logic                    stepKey_n,
  input  logic [DIV_W-1:0]        clkDevide,
  output logic                    tick,
  output logic                    clkOut,
  output logic [STEP_COUNT_W-1:0] stepCount,
  output logic [1:0]              mode
);

  localparam int CNT_W = 15 + PRESCALE;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  step_state_e      state, state_next;
  logic             run_db, key_db, key_prev, press;
  logic [CNT_W-1:0] div, div_next, term;
  logic             tick_next;

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b0)) u_run_db (
    .clk(clkIn), .rst_n(rst_n), .din(runSw), .dout(run_db)
  );

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_key_db (
    .clk(clkIn), .rst_n(rst_n), .din(stepKey_n), .dout(key_db)
  );

  // Press is the falling edge of the debounced active-low key.
  assign press = key_prev & ~key_db;

  // Terminal count follows clkDevide combinationally so rate changes act at once.
  assign term = (ONE << (32'(clkDevide) + PRESCALE)) - ONE;

  always_comb begin
    state_next = state;
    div_next   = '0;
    tick_next  = 1'b0;
    unique case (state)
      STEP_IDLE: begin
        if (run_db)     state_next = RUN;
        else if (press) state_next = STEP_FIRE;
      end
      RUN: begin
        // Leaving RUN suppresses the tick and leaves the divider cleared.
        if (!run_db)           state_next = STEP_IDLE;
        else if (div >= term)  tick_next  = 1'b1;
        else                   div_next   = div + ONE;
      end
      STEP_FIRE: begin
        tick_next  = 1'b1;
        state_next = STEP_HOLD;
      end
      STEP_HOLD: begin
        if (run_db)      state_next = RUN;
        else if (key_db) state_next = STEP_IDLE;
      end
      default: state_next = STEP_IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STEP_IDLE;
      div       <= '0;
      tick      <= 1'b0;
      clkOut    <= 1'b0;
      stepCount <= '0;
      key_prev  <= 1'b1;
    end else begin
      state    <= state_next;
      div      <= div_next;
      tick     <= tick_next;
      key_prev <= key_db;
      if (tick_next) begin
        clkOut    <= ~clkOut;
        stepCount <= stepCount + STEP_COUNT_W'(1);
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_sm_step_ctrl.sv
// tb/tb_sm_step_ctrl.sv - self-checking bench for sm_step_ctrl with a behavioural reference model
module tb_sm_step_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        key_n = 1'b1;
  logic [3:0]  cd = 4'd0;
  logic        tick, clk_out;
  logic [15:0] step_count;
  logic [1:0]  mode;

  always #5 clk = ~clk;

  sm_step_ctrl #(.DEBOUNCE_CYCLES(D), .PRESCALE(0)) dut (
    .clkIn(clk), .rst_n(rst_n), .runSw(run_sw), .stepKey_n(key_n),
    .clkDevide(cd), .tick(tick), .clkOut(clk_out), .stepCount(step_count), .mode(mode)
  );

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;

  // Reference model: mode 0 idle, 1 run, 2 fire, 3 hold.
  int m_mode, m_count, m_since;
  bit m_tick, m_clk;
  bit h_run[D+2];
  bit h_key[D+2];
  bit db_run, db_key, db_key_prev;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_since = 0; m_tick = 0; m_clk = 0;
    for (int j = 0; j < D + 2; j++) begin
      h_run[j] = 1'b0;
      h_key[j] = 1'b1;
    end
    db_run = 0; db_key = 1; db_key_prev = 1;
  endtask

  // One clock edge of the model; decisions use debounced levels from earlier edges.
  task automatic model_update();
    bit press, r, all_r, all_k;
    press  = db_key_prev & ~db_key;
    r      = db_run;
    m_tick = 0;
    case (m_mode)
      0: if (r) begin m_mode = 1; m_since = 0; end else if (press) m_mode = 2;
      1: if (!r) m_mode = 0;
         else begin
           m_since++;
           if (m_since >= (1 << cd)) begin m_tick = 1; m_since = 0; end
         end
      2: begin m_tick = 1; m_mode = 3; end
      default: if (r) begin m_mode = 1; m_since = 0; end else if (db_key) m_mode = 0;
    endcase
    if (m_tick) begin
      m_count = (m_count + 1) % 65536;
      m_clk   = ~m_clk;
    end
    db_key_prev = db_key;
    for (int j = D + 1; j > 0; j--) begin
      h_run[j] = h_run[j-1];
      h_key[j] = h_key[j-1];
    end
    h_run[0] = run_sw;
    h_key[0] = key_n;
    // Accept a level once D consecutive synchronized samples (2 edges old) disagree.
    all_r = 1; all_k = 1;
    for (int j = 2; j < D + 2; j++) begin
      if (h_run[j] == db_run) all_r = 0;
      if (h_key[j] == db_key) all_k = 0;
    end
    if (all_r) db_run = ~db_run;
    if (all_k) db_key = ~db_key;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
    check("tick", tick, m_tick);
    check("clkOut", clk_out, m_clk);
    check("stepCount", step_count, m_count);
    check("mode", mode, m_mode);
    if (tick) tick_seen++;
  endtask

  task automatic run_cycles(input int n, output int first);
    first = -1;
    for (int i = 0; i < n; i++) begin
      tick_clk();
      if (tick && first < 0) first = i;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_tick", tick, 0);
    check("rst_clkOut", clk_out, 0);
    check("rst_stepCount", step_count, 0);
    check("rst_mode", mode, 0);
    run_sw = 1'b0; key_n = 1'b1; cd = 4'd0;
    repeat (3) tick_clk();
    rst_n = 1'b1;
    tick_seen = 0;
  endtask

  initial begin
    int first, idx, last, gap_bad, base;

    do_reset();
    run_cycles(10, first);
    check("idle_no_tick", tick_seen, 0);

    // Single step: press 20 cycles, release.
    key_n = 1'b0;
    run_cycles(20, first);
    check("step_first_idx", first, 7);
    key_n = 1'b1;
    run_cycles(20, first);
    check("step_ticks", tick_seen, 1);
    check("step_count1", step_count, 1);
    check("step_clkOut1", clk_out, 1);

    // Bounce then held low.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      key_n = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
      run_cycles(1, first);
    end
    check("bounce_no_early", tick_seen, 0);
    key_n = 1'b0;
    run_cycles(20, first);
    check("bounce_first_idx", first, 7);
    key_n = 1'b1;
    run_cycles(20, first);
    check("bounce_ticks", tick_seen, 1);

    // Free run, clkDevide=3.
    do_reset();
    run_sw = 1'b1; cd = 4'd3;
    idx = 0; first = -1; last = -1; gap_bad = 0;
    while (tick_seen < 100 && idx < 2000) begin
      tick_clk();
      if (tick) begin
        if (first < 0) first = idx;
        else if (idx - last != 8) gap_bad++;
        last = idx;
      end
      idx++;
    end
    check("run_ticks_reached", tick_seen, 100);
    check("run_first_idx", first, 14);
    check("run_gap_bad", gap_bad, 0);
    check("run_count100", step_count, 100);
    check("run_mode", mode, 1);

    // Rate change at counter=6.
    base = tick_seen;
    run_cycles(6, first);
    check("rate_quiet", tick_seen - base, 0);
    cd = 4'd1;
    tick_clk();
    check("rate_next_tick", tick, 1);
    tick_clk();
    check("rate_gap", tick, 0);
    tick_clk();
    check("rate_second_tick", tick, 1);

    // Wrap and run-over-step precedence.
    do_reset();
    run_sw = 1'b1; cd = 4'd0;
    idx = 0;
    while (tick_seen < 65535 && idx < 70000) begin
      tick_clk();
      idx++;
    end
    check("wrap_preload", step_count, 65535);
    tick_clk();
    check("wrap_zero", step_count, 0);
    cd = 4'd15;
    base = tick_seen;
    key_n = 1'b0;
    run_cycles(20, first);
    key_n = 1'b1;
    run_cycles(20, first);
    check("press_in_run_ignored", tick_seen - base, 0);
    check("still_run", mode, 1);

    // Reset mid-run.
    do_reset();
    run_sw = 1'b1; cd = 4'd1;
    run_cycles(30, first);
    check("midrun_ticks", tick_seen, 11);
    do_reset();
    run_cycles(30, first);
    check("post_reset_quiet", tick_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
